// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg
// Shared constants and helpers for the operand loader slice.
//   DATA_W    : width of the data nibble and of each operand register
//   NUM_OPS   : number of operands / load strobes
//   cnt_width : width of a debounce counter that must count 0..cycles-1
package operand_loader_pkg;

   localparam int DATA_W  = 4;
   localparam int NUM_OPS = 4;

   // A single-cycle debounce still needs a 1-bit counter so the compare
   // against cycles-1 has something to look at.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/operand_loader_strobe_debounce.sv
// strobe_debounce
// Debounces one already-synchronised strobe. The stable level only changes
// after the input has disagreed with it for DEBOUNCE_CYCLES consecutive
// enabled cycles.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ena   : high = run, low = counter and stable level hold
//   in    : synchronised strobe input
//   level : debounced stable level
//   rise  : high in the cycle whose closing edge takes level from 0 to 1
module strobe_debounce
   import operand_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic in,
   output logic level,
   output logic rise
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (ena) begin
         if (in == deb_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign level = deb_q;
   // Combinational look-ahead: the parent registers its load on the same
   // edge that flips deb_q high.
   assign rise  = deb_d & ~deb_q;

endmodule

// File: rtl/operand_loader.sv
// operand_loader
// Input conditioning ahead of the four-operand datapath: synchronises the
// switches, debounces the four load strobes and, on each debounced rising
// strobe, captures the data nibble into the matching operand register.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   ui_in      : [3:0] data nibble, [7:4] load strobes for operands 1..4
//   ena        : high = run; low = debounce, operands and flags hold
//   clr        : single-cycle clear of the sticky loaded flags
//   op1..op4   : operand registers
//   load_pulse : one-cycle pulse per operand when it is loaded
//   loaded     : sticky per-operand loaded flags
//   all_loaded : AND of loaded
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W+NUM_OPS-1:0] ui_in,
   input  logic                      ena,
   input  logic                      clr,
   output logic [DATA_W-1:0]         op1,
   output logic [DATA_W-1:0]         op2,
   output logic [DATA_W-1:0]         op3,
   output logic [DATA_W-1:0]         op4,
   output logic [NUM_OPS-1:0]        load_pulse,
   output logic [NUM_OPS-1:0]        loaded,
   output logic                      all_loaded
);

   logic [DATA_W+NUM_OPS-1:0] s1_q, s2_q;
   logic [NUM_OPS-1:0]        level, rise, load;
   logic [DATA_W-1:0]         op_q [NUM_OPS];
   logic [DATA_W-1:0]         op_d [NUM_OPS];
   logic [NUM_OPS-1:0]        pulse_q, pulse_d;
   logic [NUM_OPS-1:0]        loaded_q, loaded_d;

   // Two-flop synchroniser; keeps sampling even while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= ui_in;
         s2_q <= s1_q;
      end
   end

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_strobe
      strobe_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .ena   (ena),
         .in    (s2_q[DATA_W+k]),
         .level (level[k]),
         .rise  (rise[k])
      );
   end

   // A load only ever follows a genuine low-to-high change of the stable
   // level; a strobe held high never produces a second rise.
   assign load = rise & ~level;

   always_comb begin
      pulse_d  = '0;
      loaded_d = loaded_q;
      for (int k = 0; k < NUM_OPS; k++) begin
         op_d[k] = op_q[k];
      end
      if (ena) begin
         pulse_d = load;
         // Load wins over clear for the same bit.
         loaded_d = (clr ? '0 : loaded_q) | load;
         for (int k = 0; k < NUM_OPS; k++) begin
            // Simultaneous strobes all take the same nibble.
            if (load[k]) op_d[k] = s2_q[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q  <= '0;
         loaded_q <= '0;
         for (int k = 0; k < NUM_OPS; k++) begin
            op_q[k] <= '0;
         end
      end else begin
         pulse_q  <= pulse_d;
         loaded_q <= loaded_d;
         for (int k = 0; k < NUM_OPS; k++) begin
            op_q[k] <= op_d[k];
         end
      end
   end

   assign op1        = op_q[0];
   assign op2        = op_q[1];
   assign op3        = op_q[2];
   assign op4        = op_q[3];
   assign load_pulse = pulse_q;
   assign loaded     = loaded_q;
   assign all_loaded = &loaded_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ui_in;
   logic       ena;
   logic       clr;
   logic [3:0] op1, op2, op3, op4;
   logic [3:0] load_pulse, loaded;
   logic       all_loaded;

   int n_cmp = 0;
   int n_err = 0;

   operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .ena        (ena),
      .clr        (clr),
      .op1        (op1),
      .op2        (op2),
      .op3        (op3),
      .op4        (op4),
      .load_pulse (load_pulse),
      .loaded     (loaded),
      .all_loaded (all_loaded)
   );

   always #5 clk = ~clk;

   // Reference model: synchronised sample history plus, per strobe, the
   // accepted level and how long the synchronised input has disagreed.
   logic [7:0] m_s1, m_s2;
   logic [3:0] m_deb;
   int         m_run [4];
   logic [3:0] m_op  [4];
   logic [3:0] m_pulse, m_loaded;

   task automatic model_reset();
      m_s1 = 8'h00;
      m_s2 = 8'h00;
      m_deb = 4'h0;
      m_pulse = 4'h0;
      m_loaded = 4'h0;
      for (int k = 0; k < 4; k++) begin
         m_run[k] = 0;
         m_op[k]  = 4'h0;
      end
   endtask

   task automatic model_step(input logic [7:0] u, input logic e, input logic c);
      logic [3:0] rises;
      rises = 4'h0;
      if (e) begin
         for (int k = 0; k < 4; k++) begin
            if (m_s2[4+k] != m_deb[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] >= DEB) begin
                  m_deb[k] = m_s2[4+k];
                  m_run[k] = 0;
                  if (m_deb[k]) begin
                     rises[k] = 1'b1;
                     m_op[k]  = m_s2[3:0];
                  end
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_loaded = (c ? 4'h0 : m_loaded) | rises;
      end
      m_pulse = rises;
      m_s2 = m_s1;
      m_s1 = u;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("ops", {op4, op3, op2, op1}, {m_op[3], m_op[2], m_op[1], m_op[0]});
      chk("load_pulse", {12'h0, load_pulse}, {12'h0, m_pulse});
      chk("loaded", {12'h0, loaded}, {12'h0, m_loaded});
      chk("all_loaded", {15'h0, all_loaded}, {15'h0, &m_loaded});
   endtask

   // Advance one clock: update the model with the inputs present before the
   // edge, then sample the DUT 1 time unit after the edge.
   task automatic cycle();
      if (!rst_n) model_reset();
      else        model_step(ui_in, ena, clr);
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      clr   = 1'b0;
      ui_in = 8'($urandom);
      model_reset();

      // Reset with arbitrary input
      for (int i = 0; i < 4; i++) begin
         ui_in = 8'($urandom);
         cycle();
      end
      chk("rst_ops", {op4, op3, op2, op1}, 16'h0000);
      chk("rst_pulse", {12'h0, load_pulse}, 16'h0);
      chk("rst_loaded", {11'h0, all_loaded, loaded}, 16'h0);

      // Release with 8'h1F held: first s1 sample is call 1, load at N+5
      ui_in = 8'h1F;
      rst_n = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         cycle();
         if (i == 6) begin
            chk("rel_pulse", {12'h0, load_pulse}, 16'h0001);
            chk("rel_op1", {12'h0, op1}, 16'h000F);
         end else begin
            chk("rel_nopulse", {12'h0, load_pulse}, 16'h0000);
         end
      end
      ui_in = 8'h00;
      repeat (8) cycle();

      // Glitch of 3 cycles on strobe 2
      ui_in = 8'h2A;
      repeat (3) cycle();
      ui_in = 8'h0A;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("glitch_nopulse", {12'h0, load_pulse}, 16'h0000);
      end
      chk("glitch_op2", {12'h0, op2}, 16'h0000);

      // Hold strobe 2 for exactly 4 cycles
      ui_in = 8'h2A;
      for (int i = 1; i <= 10; i++) begin
         if (i == 5) ui_in = 8'h0A;
         cycle();
         chk("hold4_pulse", {12'h0, load_pulse}, (i == 6) ? 16'h0002 : 16'h0000);
      end
      chk("hold4_op2", {12'h0, op2}, 16'h000A);
      ui_in = 8'h00;
      repeat (8) cycle();

      // Simultaneous strobes 3 and 4
      ui_in = 8'hC5;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         chk("simul_pulse", {12'h0, load_pulse}, (i == 6) ? 16'h000C : 16'h0000);
      end
      chk("simul_ops", {op4, op3, op2, op1}, 16'h55AF);
      chk("all_loaded_set", {15'h0, all_loaded}, 16'h0001);
      ui_in = 8'h00;
      repeat (8) cycle();

      // Clear on the same edge as a reload of operand 1
      ui_in = 8'h17;
      repeat (5) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      chk("clr_loaded", {12'h0, loaded}, 16'h0001);
      chk("clr_all", {15'h0, all_loaded}, 16'h0000);
      chk("clr_op1", {12'h0, op1}, 16'h0007);
      ui_in = 8'h00;
      repeat (8) cycle();

      // Enable dropped at count 2 for 10 cycles
      ui_in = 8'h28;
      repeat (4) cycle();
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("ena_nopulse", {12'h0, load_pulse}, 16'h0000);
      end
      ena = 1'b1;
      cycle();
      chk("ena_resume1", {12'h0, load_pulse}, 16'h0000);
      cycle();
      chk("ena_resume2", {12'h0, load_pulse}, 16'h0002);
      chk("ena_op2", {12'h0, op2}, 16'h0008);
      ui_in = 8'h00;
      repeat (8) cycle();

      // Reset in the middle of strobe 4 debounce
      ui_in = 8'h83;
      repeat (3) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_op4", {12'h0, op4}, 16'h0000);
      chk("midrst_loaded", {12'h0, loaded}, 16'h0000);
      check_model();
      repeat (2) cycle();
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         chk("midrst_pulse", {12'h0, load_pulse}, (i == 6) ? 16'h0008 : 16'h0000);
      end
      chk("midrst_op4_after", {12'h0, op4}, 16'h0003);
      ui_in = 8'h00;
      repeat (8) cycle();

      // Randomised segments checked against the model every cycle
      for (int s = 0; s < 80; s++) begin
         int dur;
         ui_in = 8'($urandom);
         dur = $urandom_range(1, 8);
         for (int d = 0; d < dur; d++) begin
            ena = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 19) == 0);
            cycle();
         end
      end
      ena = 1'b1;
      clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
